// File: rtl/regfile_pkg.sv
// Shared constants for the register file with scoreboard: default widths,
// depth and the hardwired-zero register index.
package regfile_pkg;

    localparam int RF_DATA_W   = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_DEPTH    = 1 << RF_ADDR_W;
    localparam int RF_ZERO_REG = 0;

endpackage

// File: rtl/regfile_busy_tracker.sv
// Per-register busy scoreboard: a new producer sets a bit, a writeback clears it.
// When a set and a clear hit the same register in one cycle, the set wins.
module regfile_busy_tracker
    import regfile_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              set_en_i,
    input  logic [ADDR_W-1:0] set_addr_i,
    input  logic [DEPTH-1:0]  clr_i,
    output logic [DEPTH-1:0]  busy_o
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    always_comb begin
        busy_d = busy_q & ~clr_i;
        if (set_en_i) begin
            busy_d[set_addr_i] = 1'b1;
        end
        // The zero register never has a producer to wait on.
        busy_d[RF_ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with busy scoreboard; x0 reads as zero.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to reads and issue readiness.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_ready_o,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    input  logic                     iss_valid_i,
    input  logic [ADDR_W-1:0]        iss_addr_i,
    output logic                     iss_ready_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(RF_ZERO_REG);

    logic [DEPTH-1:0][DATA_W-1:0] mem_q;
    logic [DEPTH-1:0][DATA_W-1:0] mem_d;

    logic [ADDR_W-1:0] wr_addr [NUM_WR];
    logic [DATA_W-1:0] wr_data [NUM_WR];
    logic [NUM_WR-1:0] wr_act;
    logic [DEPTH-1:0]  busy_clr;
    logic [DEPTH-1:0]  busy;
    logic              iss_hit;
    logic              iss_set;

    // A write is live only outside reset and when it targets a real register.
    always_comb begin
        wr_act   = '0;
        busy_clr = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            wr_addr[w] = wr_addr_i[w*ADDR_W +: ADDR_W];
            wr_data[w] = wr_data_i[w*DATA_W +: DATA_W];
            wr_act[w]  = wr_en_i[w] && !rst_i && (wr_addr[w] != ZERO_ADDR);
            if (wr_act[w]) begin
                busy_clr[wr_addr[w]] = 1'b1;
            end
        end
    end

    // Ascending port order lets the latest pipeline stage win on collisions.
    always_comb begin
        mem_d = mem_q;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_act[w]) begin
                mem_d[wr_addr[w]] = wr_data[w];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin : rd_port
            logic [ADDR_W-1:0] raddr;
            logic [DATA_W-1:0] rdata;
            logic              rhit;
            raddr = rd_addr_i[p*ADDR_W +: ADDR_W];
            rdata = mem_q[raddr];
            rhit  = 1'b0;
`ifdef REGFILE_BYPASS_EN
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_act[w] && (wr_addr[w] == raddr)) begin
                    rhit  = 1'b1;
                    rdata = wr_data[w];
                end
            end
`endif
            if (raddr == ZERO_ADDR) begin
                rdata = '0;
            end
            rd_data_o[p*DATA_W +: DATA_W] = rdata;
            rd_ready_o[p]                 = !busy[raddr] || rhit;
        end
    end

    always_comb begin
        iss_hit = 1'b0;
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_act[w] && (wr_addr[w] == iss_addr_i)) begin
                iss_hit = 1'b1;
            end
        end
`endif
        iss_ready_o = !rst_i && (!busy[iss_addr_i] || iss_hit);
        iss_set     = iss_valid_i && iss_ready_o && (iss_addr_i != ZERO_ADDR);
    end

    regfile_busy_tracker #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_busy (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .set_en_i   (iss_set),
        .set_addr_i (iss_addr_i),
        .clr_i      (busy_clr),
        .busy_o     (busy)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vectors plus a per-cycle reference model.
// Expectations follow REGFILE_BYPASS_EN when it is defined for the build.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [9:0]  rd_addr_i;
    logic [63:0] rd_data_o;
    logic [1:0]  rd_ready_o;
    logic [1:0]  wr_en_i;
    logic [9:0]  wr_addr_i;
    logic [63:0] wr_data_i;
    logic        iss_valid_i;
    logic [4:0]  iss_addr_i;
    logic        iss_ready_o;

    int checks = 0;
    int errors = 0;

    regfile_sb dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rd_addr_i   (rd_addr_i),
        .rd_data_o   (rd_data_o),
        .rd_ready_o  (rd_ready_o),
        .wr_en_i     (wr_en_i),
        .wr_addr_i   (wr_addr_i),
        .wr_data_i   (wr_data_i),
        .iss_valid_i (iss_valid_i),
        .iss_addr_i  (iss_addr_i),
        .iss_ready_o (iss_ready_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: architectural registers and outstanding-producer flags.
    logic [31:0] mdl_mem  [32];
    bit          mdl_busy [32];
    bit          chk_en = 1'b0;

    function automatic bit written_now(input logic [4:0] a);
        written_now = 1'b0;
        for (int w = 0; w < 2; w++)
            if (!rst_i && wr_en_i[w] && wr_addr_i[w*5 +: 5] == a && a != 0) written_now = 1'b1;
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        exp_data = mdl_mem[a];
        if (BYP) begin
            for (int w = 0; w < 2; w++)
                if (!rst_i && wr_en_i[w] && wr_addr_i[w*5 +: 5] == a) exp_data = wr_data_i[w*32 +: 32];
        end
        if (a == 0) exp_data = 32'h0;
    endfunction

    function automatic bit exp_ready(input logic [4:0] a);
        exp_ready = !mdl_busy[a] || (BYP && written_now(a));
    endfunction

    function automatic bit exp_iss_ready();
        exp_iss_ready = !rst_i && exp_ready(iss_addr_i);
    endfunction

    always @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) begin
                mdl_mem[i]  = 32'h0;
                mdl_busy[i] = 1'b0;
            end
            chk_en = 1'b1;
        end else if (chk_en) begin
            bit acc;
            acc = iss_valid_i && exp_iss_ready();
            for (int w = 0; w < 2; w++) begin
                if (wr_en_i[w] && wr_addr_i[w*5 +: 5] != 0) begin
                    mdl_mem[wr_addr_i[w*5 +: 5]]  = wr_data_i[w*32 +: 32];
                    mdl_busy[wr_addr_i[w*5 +: 5]] = 1'b0;
                end
            end
            if (acc && iss_addr_i != 0) mdl_busy[iss_addr_i] = 1'b1;
        end
    end

    always @(negedge clk_i) begin
        if (chk_en) begin
            chk("mdl_rd0_data", rd_data_o[31:0],  exp_data(rd_addr_i[4:0]));
            chk("mdl_rd1_data", rd_data_o[63:32], exp_data(rd_addr_i[9:5]));
            chk("mdl_rd_ready", {30'h0, rd_ready_o},
                {30'h0, exp_ready(rd_addr_i[9:5]), exp_ready(rd_addr_i[4:0])});
            chk("mdl_iss_ready", {31'h0, iss_ready_o}, {31'h0, exp_iss_ready()});
        end
    end

    task automatic idle();
        wr_en_i     = 2'b00;
        wr_addr_i   = '0;
        wr_data_i   = '0;
        iss_valid_i = 1'b0;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr_i = {a1, a0};
    endtask

    task automatic set_wr(input int port, input logic [4:0] a, input logic [31:0] d);
        wr_en_i[port]            = 1'b1;
        wr_addr_i[port*5 +: 5]   = a;
        wr_data_i[port*32 +: 32] = d;
    endtask

    task automatic issue(input logic [4:0] a);
        iss_valid_i = 1'b1;
        iss_addr_i  = a;
    endtask

    task automatic settle();
        @(negedge clk_i);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        idle();
        iss_addr_i = 5'd5;
        set_rd(5'd5, 5'd0);
        set_wr(0, 5'd5, 32'hAAAA_AAAA);
        set_wr(1, 5'd5, 32'hBBBB_BBBB);
        issue(5'd5);
        settle();
        chk("iss_ready_in_reset", {31'h0, iss_ready_o}, 32'h0);
        tick();
        settle();
        chk("rd0_in_reset", rd_data_o[31:0], 32'h0);
        tick();

        rst_i = 1'b0;
        idle();
        settle();
        chk("x5_after_reset", rd_data_o[31:0], 32'h0);
        chk("rd_ready_after_reset", {30'h0, rd_ready_o}, 32'h3);
        chk("iss_ready_after_reset", {31'h0, iss_ready_o}, 32'h1);
        tick();

        set_rd(5'd3, 5'd0);
        set_wr(0, 5'd3, 32'hDEAD_BEEF);
        settle();
        chk("x3_same_cycle", rd_data_o[31:0], BYP ? 32'hDEAD_BEEF : 32'h0);
        tick();
        idle();
        settle();
        chk("x3_next_cycle", rd_data_o[31:0], 32'hDEAD_BEEF);
        tick();

        set_rd(5'd3, 5'd7);
        set_wr(0, 5'd7, 32'h11);
        set_wr(1, 5'd7, 32'h22);
        settle();
        chk("x7_collision_bypass", rd_data_o[63:32], BYP ? 32'h22 : 32'h0);
        tick();
        idle();
        settle();
        chk("x7_collision_array", rd_data_o[63:32], 32'h22);
        tick();

        set_rd(5'd0, 5'd7);
        set_wr(1, 5'd0, 32'hFFFF_FFFF);
        issue(5'd0);
        settle();
        chk("x0_write_read", rd_data_o[31:0], 32'h0);
        chk("x0_issue_ready", {31'h0, iss_ready_o}, 32'h1);
        tick();
        idle();
        settle();
        chk("x0_after_write", rd_data_o[31:0], 32'h0);
        chk("x0_ready_after_issue", {31'h0, rd_ready_o[0]}, 32'h1);
        tick();

        set_rd(5'd9, 5'd0);
        issue(5'd9);
        settle();
        chk("x9_issue_accept", {31'h0, iss_ready_o}, 32'h1);
        tick();
        idle();
        settle();
        chk("x9_busy_rd", {31'h0, rd_ready_o[0]}, 32'h0);
        chk("x9_busy_iss", {31'h0, iss_ready_o}, 32'h0);
        tick();
        settle();
        chk("x9_still_busy", {31'h0, rd_ready_o[0]}, 32'h0);
        tick();
        set_wr(0, 5'd9, 32'h0000_0099);
        settle();
        chk("x9_write_rd_ready", {31'h0, rd_ready_o[0]}, {31'h0, BYP});
        chk("x9_write_iss_ready", {31'h0, iss_ready_o}, {31'h0, BYP});
        chk("x9_write_data", rd_data_o[31:0], BYP ? 32'h99 : 32'h0);
        tick();
        idle();
        settle();
        chk("x9_ready_after", {31'h0, rd_ready_o[0]}, 32'h1);
        chk("x9_data_after", rd_data_o[31:0], 32'h99);
        tick();

        set_rd(5'd9, 5'd12);
        set_wr(1, 5'd12, 32'h0000_C0C0);
        issue(5'd12);
        settle();
        chk("x12_issue_accept", {31'h0, iss_ready_o}, 32'h1);
        tick();
        idle();
        settle();
        chk("x12_busy_after_setclr", {31'h0, rd_ready_o[1]}, 32'h0);
        chk("x12_data_after_setclr", rd_data_o[63:32], 32'h0000_C0C0);
        chk("x12_iss_blocked", {31'h0, iss_ready_o}, 32'h0);
        tick();
        set_wr(0, 5'd12, 32'h1234_5678);
        set_wr(1, 5'd3, 32'h0BAD_F00D);
        settle();
        tick();
        idle();
        set_rd(5'd3, 5'd12);
        settle();
        chk("x12_released", {31'h0, rd_ready_o[1]}, 32'h1);
        chk("x12_final", rd_data_o[63:32], 32'h1234_5678);
        chk("x3_final", rd_data_o[31:0], 32'h0BAD_F00D);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
